// File: rtl/etroc1_event_builder.sv
// Packs the four cached channel words into one header / hit-words / trailer event per trigger.
// Optional macro EVB_EMPTY_EVENT_EN: zero-hit events still emit header + trailer.
module etroc1_event_builder #(
   parameter int         EVT_CNT_W = 16,
   parameter logic [3:0] HDR_ID    = 4'hA,
   parameter logic [3:0] TRL_ID    = 4'hB
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 trig,
   input  logic [127:0]         ch_data,
   input  logic [3:0]           ch_hit,
   input  logic [3:0]           ch_enable,
   output logic [31:0]          dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 busy,
   output logic [EVT_CNT_W-1:0] evt_cnt,
   output logic [EVT_CNT_W-1:0] drop_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HDR  = 2'd1;
   localparam logic [1:0] CH   = 2'd2;
   localparam logic [1:0] TRL  = 2'd3;

`ifdef EVB_EMPTY_EVENT_EN
   localparam bit EMPTY_EN = 1'b1;
`else
   localparam bit EMPTY_EN = 1'b0;
`endif

   logic [1:0]           state_reg;
   logic [127:0]         data_reg;
   logic [3:0]           rem_reg;
   logic [2:0]           nwords_reg;
   logic [EVT_CNT_W-1:0] evt_cnt_reg;
   logic [EVT_CNT_W-1:0] drop_cnt_reg;
   logic [31:0]          dout_reg;
   logic                 dout_valid_reg;

   logic [3:0]           sel_new;
   logic [2:0]           nwords_new;
   logic [EVT_CNT_W-1:0] evt_cnt_new;
   logic                 accept;
   logic [1:0]           low_idx;
   logic [31:0]          ch_word [4];

   assign sel_new     = ch_hit & ch_enable;
   assign nwords_new  = {2'b0, sel_new[0]} + {2'b0, sel_new[1]} + {2'b0, sel_new[2]} + {2'b0, sel_new[3]};
   assign evt_cnt_new = evt_cnt_reg + EVT_CNT_W'(1);
   assign accept      = dout_valid_reg & dout_ready;

   for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign ch_word[gi] = data_reg[gi*32 +: 32];
   end

   // Lowest remaining selected channel goes out next.
   always_comb begin
      low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (rem_reg[i]) low_idx = 2'(i);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_reg      <= IDLE;
         data_reg       <= '0;
         rem_reg        <= '0;
         nwords_reg     <= '0;
         evt_cnt_reg    <= '0;
         drop_cnt_reg   <= '0;
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
      end else begin
         if (trig) begin
            if (state_reg != IDLE) begin
               if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + EVT_CNT_W'(1);
            end else begin
               evt_cnt_reg <= evt_cnt_new;
               if (sel_new != 4'd0 || EMPTY_EN) begin
                  data_reg       <= ch_data;
                  rem_reg        <= sel_new;
                  nwords_reg     <= nwords_new;
                  dout_reg       <= {HDR_ID, evt_cnt_new[15:0], sel_new, 8'h00};
                  dout_valid_reg <= 1'b1;
                  state_reg      <= HDR;
               end
            end
         end
         // accept is only possible outside IDLE, so it never collides with the start branch.
         if (accept) begin
            case (state_reg)
               HDR, CH: begin
                  if (rem_reg != 4'd0) begin
                     dout_reg  <= ch_word[low_idx];
                     rem_reg   <= rem_reg & (rem_reg - 4'd1);
                     state_reg <= CH;
                  end else begin
                     dout_reg  <= {TRL_ID, evt_cnt_reg[15:0], 5'b0, nwords_reg, 4'h0};
                     state_reg <= TRL;
                  end
               end
               TRL: begin
                  dout_reg       <= '0;
                  dout_valid_reg <= 1'b0;
                  state_reg      <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign dout       = dout_reg;
   assign dout_valid = dout_valid_reg;
   assign busy       = (state_reg != IDLE);
   assign evt_cnt    = evt_cnt_reg;
   assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_etroc1_event_builder.sv
// Bench for etroc1_event_builder: event-queue model checked every cycle plus literal word pins.
module tb_etroc1_event_builder;

   logic         CLK = 1'b0;
   logic         RSTn;
   logic         trig;
   logic [127:0] ch_data;
   logic [3:0]   ch_hit;
   logic [3:0]   ch_enable;
   logic [31:0]  dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         busy;
   logic [15:0]  evt_cnt;
   logic [15:0]  drop_cnt;

`ifdef EVB_EMPTY_EVENT_EN
   localparam bit EMPTY_EN = 1'b1;
`else
   localparam bit EMPTY_EN = 1'b0;
`endif

   localparam logic [31:0] W0 = 32'h0ABC_DE01;
   localparam logic [31:0] W1 = 32'h4123_4561;
   localparam logic [31:0] W2 = 32'h8765_4321;
   localparam logic [31:0] W3 = 32'hC0FF_EE01;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_q[$];
   logic [31:0] acc_q[$];
   int unsigned m_evt = 0;
   int unsigned m_drop = 0;

   etroc1_event_builder dut (
      .CLK(CLK), .RSTn(RSTn), .trig(trig), .ch_data(ch_data), .ch_hit(ch_hit),
      .ch_enable(ch_enable), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .busy(busy), .evt_cnt(evt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Event model: the whole expected word list of an event is queued at trigger time.
   always @(posedge CLK or negedge RSTn) begin : model
      logic       was_busy;
      logic [3:0] sel;
      int unsigned n;
      if (!RSTn) begin
         m_q.delete();
         m_evt  = 0;
         m_drop = 0;
      end else begin
         was_busy = (m_q.size() != 0);
         if (was_busy && dout_ready) void'(m_q.pop_front());
         if (trig) begin
            if (was_busy) begin
               if (m_drop < 65535) m_drop++;
            end else begin
               m_evt = (m_evt + 1) % 65536;
               sel = ch_hit & ch_enable;
               if (sel != 0 || EMPTY_EN) begin
                  n = 0;
                  m_q.push_back(32'hA000_0000 + m_evt * 4096 + sel * 256);
                  for (int i = 0; i < 4; i++) begin
                     if (sel[i]) begin
                        m_q.push_back(ch_data[i*32 +: 32]);
                        n++;
                     end
                  end
                  m_q.push_back(32'hB000_0000 + m_evt * 4096 + n * 16);
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (RSTn === 1'b1) begin
         check("valid", {31'b0, dout_valid}, {31'b0, m_q.size() != 0});
         check("busy", {31'b0, busy}, {31'b0, m_q.size() != 0});
         if (m_q.size() != 0) check("dout", dout, m_q[0]);
         check("evt_cnt", {16'b0, evt_cnt}, m_evt);
         check("drop_cnt", {16'b0, drop_cnt}, m_drop);
         if (dout_valid && dout_ready) acc_q.push_back(dout);
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic fire(input logic [3:0] hit, input logic [3:0] en);
      ch_hit    = hit;
      ch_enable = en;
      trig      = 1'b1;
      tick();
      trig      = 1'b0;
      ch_hit    = 4'hX;
   endtask

   task automatic pin(input string name, input int idx, input logic [31:0] exp);
      logic [31:0] got;
      got = (idx < acc_q.size()) ? acc_q[idx] : 32'hDEAD_DEAD;
      check(name, got, exp);
   endtask

   initial begin
      RSTn = 1'b0; trig = 1'b0; dout_ready = 1'b1;
      ch_data = {W3, W2, W1, W0}; ch_hit = 4'h0; ch_enable = 4'hF;
      tick(3);
      check("rst_dout", dout, 32'h0);
      check("rst_valid", {31'b0, dout_valid}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_evt", {16'b0, evt_cnt}, 32'h0);
      RSTn = 1'b1;
      tick(2);

      // 1: two hits, ready high
      acc_q.delete();
      fire(4'b0101, 4'hF);
      tick(6);
      check("t1_nwords", acc_q.size(), 4);
      pin("t1_hdr", 0, 32'hA000_1500);
      pin("t1_ch0", 1, W0);
      pin("t1_ch2", 2, W2);
      pin("t1_trl", 3, 32'hB000_1020);
      check("t1_evt", {16'b0, evt_cnt}, 32'd1);

      // 2: same event under back-pressure
      acc_q.delete();
      dout_ready = 1'b1;
      fire(4'b0101, 4'hF);
      for (int i = 0; i < 12; i++) begin
         dout_ready = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
         tick();
      end
      dout_ready = 1'b1;
      tick(3);
      check("t2_nwords", acc_q.size(), 4);
      pin("t2_hdr", 0, 32'hA000_2500);
      pin("t2_trl", 3, 32'hB000_2020);

      // 3: trigger three cycles in a row
      acc_q.delete();
      ch_hit = 4'hF; ch_enable = 4'hF; trig = 1'b1;
      tick(3);
      trig = 1'b0;
      tick(8);
      pin("t3_hdr", 0, 32'hA000_3F00);
      pin("t3_trl", 5, 32'hB000_3040);
      check("t3_drop", {16'b0, drop_cnt}, 32'd2);

      // 4: zero-hit event
      acc_q.delete();
      fire(4'b0000, 4'hF);
      tick(4);
      if (EMPTY_EN) begin
         check("t4_nwords", acc_q.size(), 2);
         pin("t4_hdr", 0, 32'hA000_4000);
         pin("t4_trl", 1, 32'hB000_4000);
      end else begin
         check("t4_nwords", acc_q.size(), 0);
      end
      check("t4_evt", {16'b0, evt_cnt}, 32'd4);

      // 5: enable mask restricts hits
      acc_q.delete();
      fire(4'hF, 4'b0011);
      tick(6);
      check("t5_nwords", acc_q.size(), 4);
      pin("t5_hdr", 0, 32'hA000_5300);
      pin("t5_ch0", 1, W0);
      pin("t5_ch1", 2, W1);
      pin("t5_trl", 3, 32'hB000_5020);

      // trig on trailer acceptance is dropped, next cycle accepted
      acc_q.delete();
      fire(4'b0001, 4'hF);
      tick(2);
      ch_hit = 4'b0010; trig = 1'b1;
      tick(2);
      trig = 1'b0;
      tick(6);
      check("t6_drop", {16'b0, drop_cnt}, 32'd3);
      check("t6_evt", {16'b0, evt_cnt}, 32'd7);
      pin("t6_hdr2", 3, 32'hA000_7200);

      // 6: reset mid-event while stalled
      dout_ready = 1'b0;
      fire(4'hF, 4'hF);
      tick(2);
      RSTn = 1'b0;
      #1;
      check("t7_valid", {31'b0, dout_valid}, 32'h0);
      check("t7_busy", {31'b0, busy}, 32'h0);
      check("t7_evt", {16'b0, evt_cnt}, 32'h0);
      check("t7_drop", {16'b0, drop_cnt}, 32'h0);
      tick(2);
      RSTn = 1'b1;
      dout_ready = 1'b1;
      tick();
      acc_q.delete();
      fire(4'hF, 4'hF);
      tick(8);
      pin("t7_hdr", 0, 32'hA000_1F00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
